// File: rtl/branch_sequencer.sv
// Fetch / conditional-branch control sequencer: drives datapath strobes for
// T0-T2 fetch with a bounded memory wait, then T3-T6 for the branch opcode.
module branch_sequencer #(
  parameter logic [4:0]  BR_OPCODE    = 5'b10010,
  parameter int unsigned MEM_WAIT_MAX = 15
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic        start,
  input  logic [31:0] ir,
  input  logic        mem_ready,
  input  logic        con,
  output logic        pc_out,
  output logic        mar_in,
  output logic        inc_pc,
  output logic        z_in,
  output logic        zlow_out,
  output logic        pc_in,
  output logic        mem_read,
  output logic        mdr_in,
  output logic        mdr_out,
  output logic        ir_in,
  output logic        gra,
  output logic        r_out,
  output logic        con_in_en,
  output logic        y_in,
  output logic        c_out,
  output logic        alu_add,
  output logic        busy,
  output logic        handoff,
  output logic        done,
  output logic        mem_err
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    T0   = 3'd1,
    T1   = 3'd2,
    T2   = 3'd3,
    T3   = 3'd4,
    T4   = 3'd5,
    T5   = 3'd6,
    T6   = 3'd7
  } state_t;

  localparam logic [7:0] WaitMax = 8'(MEM_WAIT_MAX);

  state_t     state_q;
  logic [7:0] wait_cnt_q;
  logic       is_branch;
  logic       unused_ir;

  assign is_branch = (ir[31:27] == BR_OPCODE);
  assign unused_ir = ^ir[26:0];

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q    <= IDLE;
      wait_cnt_q <= 8'd0;
    end else begin
      case (state_q)
        IDLE: if (start) state_q <= T0;
        T0: begin
          wait_cnt_q <= 8'd0;
          state_q    <= T1;
        end
        // A ready response wins over a timeout landing in the same cycle.
        T1: begin
          if (mem_ready) begin
            state_q <= T2;
          end else if (wait_cnt_q < WaitMax) begin
            wait_cnt_q <= wait_cnt_q + 8'd1;
          end else begin
            state_q <= IDLE;
          end
        end
        T2: state_q <= T3;
        T3: state_q <= is_branch ? T4 : IDLE;
        T4: state_q <= T5;
        T5: state_q <= T6;
        T6: state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  always_comb begin
    pc_out    = 1'b0;
    mar_in    = 1'b0;
    inc_pc    = 1'b0;
    z_in      = 1'b0;
    zlow_out  = 1'b0;
    pc_in     = 1'b0;
    mem_read  = 1'b0;
    mdr_in    = 1'b0;
    mdr_out   = 1'b0;
    ir_in     = 1'b0;
    gra       = 1'b0;
    r_out     = 1'b0;
    con_in_en = 1'b0;
    y_in      = 1'b0;
    c_out     = 1'b0;
    alu_add   = 1'b0;
    handoff   = 1'b0;
    done      = 1'b0;
    mem_err   = 1'b0;
    busy      = (state_q != IDLE);
    case (state_q)
      T0: begin
        pc_out = 1'b1;
        mar_in = 1'b1;
        inc_pc = 1'b1;
        z_in   = 1'b1;
      end
      T1: begin
        mem_read = 1'b1;
        if (mem_ready) begin
          zlow_out = 1'b1;
          pc_in    = 1'b1;
          mdr_in   = 1'b1;
        end else if (wait_cnt_q >= WaitMax) begin
          mem_err = 1'b1;
        end
      end
      T2: begin
        mdr_out = 1'b1;
        ir_in   = 1'b1;
      end
      T3: begin
        if (is_branch) begin
          gra       = 1'b1;
          r_out     = 1'b1;
          con_in_en = 1'b1;
        end else begin
          handoff = 1'b1;
        end
      end
      T4: begin
        pc_out = 1'b1;
        y_in   = 1'b1;
      end
      T5: begin
        c_out   = 1'b1;
        alu_add = 1'b1;
        z_in    = 1'b1;
      end
      // The PC only takes the branch target when the condition holds.
      T6: begin
        done     = 1'b1;
        zlow_out = con;
        pc_in    = con;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_branch_sequencer.sv
// Scoreboard bench for branch_sequencer: expected output vectors are queued
// as each step is driven and compared once per cycle on the falling edge.
module tb_branch_sequencer;

  logic        clock;
  logic        resetn;
  logic        start;
  logic [31:0] ir;
  logic        mem_ready;
  logic        con;
  logic pc_out, mar_in, inc_pc, z_in, zlow_out, pc_in, mem_read, mdr_in;
  logic mdr_out, ir_in, gra, r_out, con_in_en, y_in, c_out, alu_add;
  logic busy, handoff, done, mem_err;
  logic [19:0] obsVec;

  int checks = 0;
  int errors = 0;
  logic [19:0] expQ[$];
  string       tagQ[$];

  localparam logic [19:0] PC_OUT = 20'h80000, MAR_IN = 20'h40000, INC_PC = 20'h20000;
  localparam logic [19:0] Z_IN = 20'h10000, ZLOW = 20'h08000, PC_IN = 20'h04000;
  localparam logic [19:0] MEM_READ = 20'h02000, MDR_IN = 20'h01000, MDR_OUT = 20'h00800;
  localparam logic [19:0] IR_IN = 20'h00400, GRA = 20'h00200, R_OUT = 20'h00100;
  localparam logic [19:0] CON_IN = 20'h00080, Y_IN = 20'h00040, C_OUT = 20'h00020;
  localparam logic [19:0] ALU_ADD = 20'h00010, BUSY = 20'h00008, HANDOFF = 20'h00004;
  localparam logic [19:0] DONE = 20'h00002, MEM_ERR = 20'h00001;

  localparam logic [19:0] V_IDLE   = 20'h0;
  localparam logic [19:0] V_T0     = PC_OUT | MAR_IN | INC_PC | Z_IN | BUSY;
  localparam logic [19:0] V_T1W    = MEM_READ | BUSY;
  localparam logic [19:0] V_T1R    = MEM_READ | ZLOW | PC_IN | MDR_IN | BUSY;
  localparam logic [19:0] V_T1E    = MEM_READ | MEM_ERR | BUSY;
  localparam logic [19:0] V_T2     = MDR_OUT | IR_IN | BUSY;
  localparam logic [19:0] V_T3BR   = GRA | R_OUT | CON_IN | BUSY;
  localparam logic [19:0] V_T3NB   = HANDOFF | BUSY;
  localparam logic [19:0] V_T4     = PC_OUT | Y_IN | BUSY;
  localparam logic [19:0] V_T5     = C_OUT | ALU_ADD | Z_IN | BUSY;
  localparam logic [19:0] V_T6C1   = ZLOW | PC_IN | DONE | BUSY;
  localparam logic [19:0] V_T6C0   = DONE | BUSY;

  localparam logic [31:0] IR_BR = 32'h9080_0023;
  localparam logic [31:0] IR_NB = 32'h1088_0000;

  branch_sequencer #(.BR_OPCODE(5'b10010), .MEM_WAIT_MAX(15)) dut (
    .clock(clock), .resetn(resetn), .start(start), .ir(ir),
    .mem_ready(mem_ready), .con(con),
    .pc_out(pc_out), .mar_in(mar_in), .inc_pc(inc_pc), .z_in(z_in),
    .zlow_out(zlow_out), .pc_in(pc_in), .mem_read(mem_read), .mdr_in(mdr_in),
    .mdr_out(mdr_out), .ir_in(ir_in), .gra(gra), .r_out(r_out),
    .con_in_en(con_in_en), .y_in(y_in), .c_out(c_out), .alu_add(alu_add),
    .busy(busy), .handoff(handoff), .done(done), .mem_err(mem_err)
  );

  assign obsVec = {pc_out, mar_in, inc_pc, z_in, zlow_out, pc_in, mem_read, mdr_in,
                   mdr_out, ir_in, gra, r_out, con_in_en, y_in, c_out, alu_add,
                   busy, handoff, done, mem_err};

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic applyStimulus(input logic s, input logic [31:0] i, input logic c,
                               input logic r);
    start     = s;
    ir        = i;
    con       = c;
    mem_ready = r;
  endtask

  task automatic pushExp(input logic [19:0] v, input string t);
    expQ.push_back(v);
    tagQ.push_back(t);
  endtask

  // Samples on the falling edge, then returns just after the next rising edge.
  task automatic checkOutput();
    logic [19:0] e;
    string       t;
    @(negedge clock);
    checks++;
    if (expQ.size() == 0) begin
      errors++;
      $error("[TB] FAIL scoreboard_empty observed=%h expected=none", obsVec);
    end else begin
      e = expQ.pop_front();
      t = tagQ.pop_front();
      assert (obsVec === e) else begin
        errors++;
        $error("[TB] FAIL %s observed=%h expected=%h", t, obsVec, e);
      end
    end
    @(posedge clock);
    #1;
  endtask

  task automatic launch(input logic [31:0] i, input logic c, input logic r);
    applyStimulus(1'b1, i, c, r);
    @(posedge clock);
    #1;
    start = 1'b0;
  endtask

  task automatic branchSeq(input logic c, input int delay, input string name);
    launch(IR_BR, c, delay == 0);
    pushExp(V_T0, {name, "_t0"}); checkOutput();
    for (int k = 0; k < delay; k++) begin
      pushExp(V_T1W, {name, "_t1wait"}); checkOutput();
    end
    mem_ready = 1'b1;
    pushExp(V_T1R, {name, "_t1ready"}); checkOutput();
    mem_ready = 1'b0;
    pushExp(V_T2, {name, "_t2"}); checkOutput();
    pushExp(V_T3BR, {name, "_t3"}); checkOutput();
    pushExp(V_T4, {name, "_t4"}); checkOutput();
    pushExp(V_T5, {name, "_t5"}); checkOutput();
    pushExp(c ? V_T6C1 : V_T6C0, {name, "_t6"}); checkOutput();
    pushExp(V_IDLE, {name, "_idle"}); checkOutput();
  endtask

  initial begin
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
    resetn = 1'b0;
    #1;
    checks++;
    assert (obsVec === V_IDLE) else begin
      errors++;
      $error("[TB] FAIL reset_state observed=%h expected=%h", obsVec, V_IDLE);
    end
    @(posedge clock);
    @(posedge clock);
    #1;
    resetn = 1'b1;
    pushExp(V_IDLE, "idle_after_reset"); checkOutput();

    branchSeq(1'b1, 0, "br_con1");
    branchSeq(1'b0, 0, "br_con0");

    // Condition changes outside T6 must not matter.
    launch(IR_BR, 1'b0, 1'b1);
    pushExp(V_T0, "conlate_t0"); checkOutput();
    con = 1'b1;
    pushExp(V_T1R, "conlate_t1"); checkOutput();
    pushExp(V_T2, "conlate_t2"); checkOutput();
    pushExp(V_T3BR, "conlate_t3"); checkOutput();
    con = 1'b0;
    pushExp(V_T4, "conlate_t4"); checkOutput();
    con = 1'b1;
    pushExp(V_T5, "conlate_t5"); checkOutput();
    con = 1'b0;
    pushExp(V_T6C0, "conlate_t6"); checkOutput();
    pushExp(V_IDLE, "conlate_idle"); checkOutput();

    launch(IR_NB, 1'b1, 1'b1);
    pushExp(V_T0, "nb_t0"); checkOutput();
    pushExp(V_T1R, "nb_t1"); checkOutput();
    pushExp(V_T2, "nb_t2"); checkOutput();
    pushExp(V_T3NB, "nb_t3"); checkOutput();
    pushExp(V_IDLE, "nb_idle"); checkOutput();

    branchSeq(1'b1, 3, "wait3");

    // Timeout with start pulses sprinkled through the busy period.
    launch(IR_BR, 1'b1, 1'b0);
    pushExp(V_T0, "tmo_t0"); checkOutput();
    for (int k = 0; k < 15; k++) begin
      start = k[0];
      pushExp(V_T1W, "tmo_t1wait"); checkOutput();
    end
    start = 1'b1;
    pushExp(V_T1E, "tmo_err"); checkOutput();
    start = 1'b0;
    pushExp(V_IDLE, "tmo_idle"); checkOutput();
    pushExp(V_IDLE, "tmo_idle2"); checkOutput();

    // Ready arriving exactly when the timeout would fire.
    launch(IR_BR, 1'b1, 1'b0);
    pushExp(V_T0, "edge_t0"); checkOutput();
    for (int k = 0; k < 15; k++) begin
      pushExp(V_T1W, "edge_t1wait"); checkOutput();
    end
    mem_ready = 1'b1;
    pushExp(V_T1R, "edge_ready"); checkOutput();
    mem_ready = 1'b0;
    pushExp(V_T2, "edge_t2"); checkOutput();
    pushExp(V_T3BR, "edge_t3"); checkOutput();
    pushExp(V_T4, "edge_t4"); checkOutput();
    pushExp(V_T5, "edge_t5"); checkOutput();
    pushExp(V_T6C1, "edge_t6"); checkOutput();
    pushExp(V_IDLE, "edge_idle"); checkOutput();

    // Asynchronous reset in the middle of T4.
    launch(IR_BR, 1'b1, 1'b1);
    pushExp(V_T0, "rst_t0"); checkOutput();
    pushExp(V_T1R, "rst_t1"); checkOutput();
    pushExp(V_T2, "rst_t2"); checkOutput();
    pushExp(V_T3BR, "rst_t3"); checkOutput();
    #2;
    checks++;
    assert (obsVec === V_T4) else begin
      errors++;
      $error("[TB] FAIL rst_pre_t4 observed=%h expected=%h", obsVec, V_T4);
    end
    resetn = 1'b0;
    #1;
    checks++;
    assert (obsVec === V_IDLE) else begin
      errors++;
      $error("[TB] FAIL rst_async observed=%h expected=%h", obsVec, V_IDLE);
    end
    @(posedge clock);
    #1;
    resetn = 1'b1;
    pushExp(V_IDLE, "rst_idle"); checkOutput();
    branchSeq(1'b1, 1, "post_rst");

    checks++;
    assert (expQ.size() == 0) else begin
      errors++;
      $error("[TB] FAIL scoreboard_drain observed=%0d expected=0", expQ.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
